// File: rtl/uart_tx_fsm_if.sv
// Handshake bundle between the UART frame controller, its upstream byte source
// and the TX serializer.
interface uart_tx_fsm_if #(
  parameter int unsigned DATA_LENGTH = 8
);
  logic                   Data_valid;
  logic [DATA_LENGTH-1:0] P_DATA;
  logic                   PAR_EN;
  logic                   PAR_TYP;
  logic                   ser_data;
  logic                   ser_done;
  logic                   ser_en;
  logic                   TX_OUT;
  logic                   busy;

  modport master (
    output Data_valid, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, TX_OUT, busy
  );

  modport slave (
    input  Data_valid, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: sequences start, data, optional parity and
// stop phases on TX_OUT and paces the serializer through ser_en.
module uart_tx_fsm #(
  parameter int unsigned DATA_LENGTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_fsm_if.slave  bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       accept_c;
  logic       par_bit_r;
  logic       par_en_r;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; Data_valid only matters in IDLE
  always_comb begin
    next_state = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Data_valid) begin
          next_state = START;
          accept_c   = 1'b1;
        end
      end
      START:  next_state = DATA;
      DATA: begin
        if (bus.ser_done) begin
          next_state = par_en_r ? PARITY : STOP;
        end
      end
      PARITY: next_state = STOP;
      STOP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame configuration captured once at acceptance so mid-frame changes are inert
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bit_r <= 1'b0;
      par_en_r  <= 1'b0;
    end else if (accept_c) begin
      par_bit_r <= (^bus.P_DATA[DATA_LENGTH-1:0]) ^ bus.PAR_TYP;
      par_en_r  <= bus.PAR_EN;
    end
  end

  // Outputs decoded straight from the state register; async reset forces the idle-high line
  always_comb begin
    bus.TX_OUT = 1'b1;
    bus.ser_en = 1'b0;
    bus.busy   = (state != IDLE);
    case (state)
      START: begin
        bus.TX_OUT = 1'b0;
        bus.ser_en = 1'b1;
      end
      DATA: begin
        bus.TX_OUT = bus.ser_data;
        bus.ser_en = ~bus.ser_done;
      end
      PARITY:  bus.TX_OUT = par_bit_r;
      default: bus.TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm with a small LSB-first serializer model.
module tb_uart_tx_fsm;

  localparam int unsigned DL = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;
  bit   stuck  = 1'b0;

  logic [DL-1:0] sh;
  int            idx;

  uart_tx_fsm_if #(.DATA_LENGTH(DL)) bus ();

  uart_tx_fsm #(.DATA_LENGTH(DL)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Serializer model: loads on acceptance, shifts one bit per enabled cycle
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh           <= '0;
      idx          <= DL;
      bus.ser_data <= 1'b1;
    end else if (bus.Data_valid && !bus.busy) begin
      sh  <= bus.P_DATA;
      idx <= 0;
    end else if (bus.ser_en) begin
      bus.ser_data <= sh[0];
      sh           <= sh >> 1;
      idx          <= idx + 1;
    end
  end

  assign bus.ser_done = !stuck && (idx == int'(DL));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, " tx"},   32'(bus.TX_OUT), 32'd1);
    check({tag, " busy"}, 32'(bus.busy),   32'd0);
    check({tag, " en"},   32'(bus.ser_en), 32'd0);
  endtask

  // exp_bits[i] is the expected TX_OUT in the i-th frame cycle (bit 0 = start)
  task automatic send_frame(input string name, input logic [7:0] d, input logic pen,
                            input logic ptyp, input logic [10:0] exp_bits,
                            input int len, input bit glitch);
    int en_cnt;
    en_cnt = 0;
    @(negedge CLK);
    bus.Data_valid = 1'b1;
    bus.P_DATA     = d;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    @(negedge CLK);
    bus.Data_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s tx[%0d]", name, i),   32'(bus.TX_OUT), 32'(exp_bits[i]));
      check($sformatf("%s busy[%0d]", name, i), 32'(bus.busy),   32'd1);
      check($sformatf("%s en[%0d]", name, i),   32'(bus.ser_en), (i < 8) ? 32'd1 : 32'd0);
      if (bus.ser_en) en_cnt++;
      if (glitch && i == 4) begin
        bus.Data_valid = 1'b1;
        bus.P_DATA     = 8'hFF;
        bus.PAR_EN     = ~pen;
        bus.PAR_TYP    = ~ptyp;
      end else if (glitch && i == 5) begin
        bus.Data_valid = 1'b0;
      end
      @(negedge CLK);
    end
    check({name, " en_count"}, 32'(en_cnt), 32'd8);
    idle_check({name, " post0"});
    @(negedge CLK);
    idle_check({name, " post1"});
  endtask

  logic [10:0] a5_bits;

  initial begin
    bus.Data_valid = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    #2;
    idle_check("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    idle_check("after_reset");

    // A5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    a5_bits = 11'b10101001010;
    send_frame("a5_even", 8'hA5, 1'b1, 1'b0, a5_bits, 11, 1'b0);
    // 07 odd parity -> parity bit 0
    send_frame("07_odd", 8'h07, 1'b1, 1'b1, 11'b10000001110, 11, 1'b0);
    // 07 without parity -> 10-cycle frame
    send_frame("07_nopar", 8'h07, 1'b0, 1'b0, 11'b01000001110, 10, 1'b0);
    // 00 even parity with FF strobe and config flips mid-frame
    send_frame("00_glitch_even", 8'h00, 1'b1, 1'b0, 11'b10000000000, 11, 1'b1);
    // 00 odd parity: parity 1 must survive PAR_EN/PAR_TYP flips
    send_frame("00_glitch_odd", 8'h00, 1'b1, 1'b1, 11'b11000000000, 11, 1'b1);

    // Back-to-back with Data_valid held high
    @(negedge CLK);
    bus.Data_valid = 1'b1;
    bus.P_DATA     = 8'hA5;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("b2b1 tx[%0d]", i),   32'(bus.TX_OUT), 32'(a5_bits[i]));
      check($sformatf("b2b1 busy[%0d]", i), 32'(bus.busy),   32'd1);
      @(negedge CLK);
    end
    check("b2b gap tx",   32'(bus.TX_OUT), 32'd1);
    check("b2b gap busy", 32'(bus.busy),   32'd0);
    @(negedge CLK);
    bus.Data_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("b2b2 tx[%0d]", i),   32'(bus.TX_OUT), 32'(a5_bits[i]));
      check($sformatf("b2b2 busy[%0d]", i), 32'(bus.busy),   32'd1);
      @(negedge CLK);
    end
    idle_check("b2b end");

    // ser_done stuck low: hold in DATA until reset
    stuck = 1'b1;
    @(negedge CLK);
    bus.Data_valid = 1'b1;
    bus.P_DATA     = 8'h3C;
    @(negedge CLK);
    bus.Data_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (i % 10 == 9) begin
        check($sformatf("stuck busy[%0d]", i), 32'(bus.busy),   32'd1);
        check($sformatf("stuck en[%0d]", i),   32'(bus.ser_en), 32'd1);
      end
    end
    RST = 1'b1;
    #1;
    idle_check("mid_data_reset");
    @(negedge CLK);
    RST   = 1'b0;
    stuck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      idle_check($sformatf("idle_hold[%0d]", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
# uart_tx_fsm

Frame controller for the UART transmitter. It sits directly downstream of the TX serializer and drives it through `ser_en`. It accepts a byte-valid strobe, computes the parity bit, and sequences the serial line through the start, data, optional parity and stop phases. It is the sole driver of the TX line and of the transmitter `busy` flag.

## Interface
Parameters:
- `DATA_LENGTH`, default 8: data bits per frame; must match the serializer.

Ports (one clock, `CLK`; reset `RST` is asynchronous and active-high):
- `CLK`  in  1  transmit bit clock; one UART bit per cycle.
- `RST`  in  1  asynchronous, active-high reset.
- `Data_valid`  in  1  upstream strobe; `P_DATA` is valid this cycle.
- `P_DATA`  in  DATA_LENGTH  parallel byte; used here only for parity.
- `PAR_EN`  in  1  1 = frame carries a parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `ser_data`  in  1  current serial data bit from the serializer (registered there).
- `ser_done`  in  1  high in the cycle the last data bit is on `ser_data`.
- `ser_en`  out  1  serializer shift enable.
- `TX_OUT`  out  1  UART serial line; idle high.
- `busy`  out  1  high while a frame is in progress.

## Operation
- Registered state: IDLE, START, DATA, PARITY, STOP.
- Frame configuration is latched at acceptance: `par_bit_r` = (XOR-reduce of `P_DATA`) XOR `PAR_TYP`, and `par_en_r` = `PAR_EN`.
  - `PAR_EN`, `PAR_TYP` and `P_DATA` changes mid-frame have no effect on the current frame.
- Transitions:
  - IDLE -> START when `Data_valid`=1. This is the acceptance cycle; `par_bit_r` and `par_en_r` load here.
  - START -> DATA unconditionally after 1 cycle.
  - DATA -> PARITY when `ser_done`=1 and `par_en_r`=1.
  - DATA -> STOP when `ser_done`=1 and `par_en_r`=0.
  - PARITY -> STOP unconditionally after 1 cycle.
  - STOP -> IDLE unconditionally after 1 cycle.
- `Data_valid` is ignored in every state except IDLE. No queuing; upstream must wait for `busy`=0.
- Outputs are decoded from the registered state; no extra output registers.
  - `TX_OUT`: IDLE=1, START=0, DATA=`ser_data`, PARITY=`par_bit_r`, STOP=1.
  - `ser_en` = (state==START) OR (state==DATA AND NOT `ser_done`). Enable in START pre-loads the serializer's registered output, so bit 0 appears on `ser_data` in the first DATA cycle.
  - `busy` = (state != IDLE).
- If `ser_done` never asserts, the block stays in DATA with `ser_en`=1 until reset. No timeout.
- `ser_done` high outside DATA is ignored.

## Timing
- Reset (async assert, any state): state=IDLE, `par_bit_r`=0, `par_en_r`=0.
  - Outputs during and after reset: `TX_OUT`=1, `ser_en`=0, `busy`=0.
  - Reset mid-frame truncates the frame. The line returns high immediately, with no glitch low beyond the reset edge.
- Latency: `Data_valid` in cycle n puts the start bit on `TX_OUT` in cycle n+1. `busy` also rises in cycle n+1.
- With a conforming serializer, DATA lasts exactly DATA_LENGTH cycles, LSB first.
- Frame length: 1 + DATA_LENGTH + `par_en_r` + 1 cycles (10 or 11 for DATA_LENGTH=8).
- `busy` falls in the cycle after STOP. The earliest next acceptance is that IDLE cycle, so there is at least 1 idle-high cycle between frames.
- DATA_LENGTH is any value at least 1. Parity is computed over the full DATA_LENGTH width.

## Test plan
- Reset: `RST`=1 mid-DATA -> same cycle `TX_OUT`=1, `busy`=0, `ser_en`=0. After release, IDLE holds with `Data_valid`=0.
- Even parity: `P_DATA`=8'hA5, `PAR_EN`=1, `PAR_TYP`=0, serializer model attached.
  - `TX_OUT` sequence from cycle n+1: 0,1,0,1,0,0,1,0,1,0,1, i.e. start, LSB-first data, parity=0, stop.
  - `busy` high for exactly 11 cycles.
- Odd parity, no-parity: `P_DATA`=8'h07, `PAR_TYP`=1 -> parity bit 0 (3 ones). Same byte with `PAR_EN`=0 -> 10-cycle frame, stop directly after the 8th data bit.
- Ignored strobe: pulse `Data_valid` with `P_DATA`=8'hFF during DATA of a frame carrying 8'h00 -> frame bits unchanged, no second frame started.
  - Same check with `PAR_EN` toggled mid-frame -> parity phase unchanged.
- `ser_en` shape: per frame, exactly 8 cycles high (START plus 7 DATA cycles). It is low in the ser_done cycle, PARITY, STOP and IDLE.
- Back-to-back: `Data_valid` held high continuously -> frames separated by exactly one IDLE cycle of `TX_OUT`=1. `ser_done` stuck at 0 -> remains in DATA with `busy`=1 until `RST`.
